// File: rtl/proc_dmem_responder_if.sv
// Request/response val/rdy streams between the processor dmem port and its responder.
// master = processor side, slave = memory responder side.
interface proc_dmem_responder_if;
   logic        reqstream_val;
   logic        reqstream_rdy;
   logic [76:0] reqstream_msg;
   logic        respstream_val;
   logic        respstream_rdy;
   logic [46:0] respstream_msg;

   modport master (
      output reqstream_val, reqstream_msg, respstream_rdy,
      input  reqstream_rdy, respstream_val, respstream_msg
   );

   modport slave (
      input  reqstream_val, reqstream_msg, respstream_rdy,
      output reqstream_rdy, respstream_val, respstream_msg
   );
endinterface

// File: rtl/proc_dmem_responder.sv
// Single-outstanding data-memory responder with fixed programmable latency.
// Optional PROC_DMEM_RESPONDER_BOUNDS_CHECK_EN flags out-of-range addresses.
module proc_dmem_responder #(
   parameter int p_mem_words = 256,
   parameter int p_latency   = 1
) (
   input logic clk,
   input logic reset,
   proc_dmem_responder_if.slave dmem
);
   localparam int AW = $clog2(p_mem_words);

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

   state_t      state;
   logic [3:0]  cnt;
   logic        resp_val;
   logic [46:0] resp_msg;
   logic [31:0] mem [p_mem_words];

   logic [2:0]    typ;
   logic [7:0]    opq;
   logic [31:0]   addr;
   logic [1:0]    len;
   logic [31:0]   wdata;
   logic [AW-1:0] widx;
   logic [1:0]    off;
   logic [2:0]    n;
   logic [31:0]   lane_mask;
   logic [31:0]   len_mask;
   logic [31:0]   shifted_w;
   logic [31:0]   rdata;
   logic          is_read;
   logic          is_wr;
   logic          oob;
   logic          do_write;
   logic [1:0]    test;
   logic [31:0]   resp_data;

   assign {typ, opq, addr, len, wdata} = dmem.reqstream_msg;
   assign widx = addr[AW+1:2];
   assign off  = addr[1:0];
   assign n    = (len == 2'd0) ? 3'd4 : {1'b0, len};

   assign is_read = (typ == 3'd0);
   assign is_wr   = (typ == 3'd1) || (typ == 3'd2);

`ifdef PROC_DMEM_RESPONDER_BOUNDS_CHECK_EN
   assign oob = |addr[31:AW+2];
`else
   logic unused_hi;
   assign oob       = 1'b0;
   assign unused_hi = ^addr[31:AW+2];
`endif

   // Byte-lane masks: active write lanes and low n bytes of read data.
   always_comb begin
      int o;
      int k;
      lane_mask = '0;
      len_mask  = '0;
      o = int'(off);
      k = int'(n);
      for (int i = 0; i < 4; i++) begin
         if (i >= o && i < o + k) lane_mask[8*i +: 8] = 8'hff;
         if (i < k) len_mask[8*i +: 8] = 8'hff;
      end
   end

   assign shifted_w = wdata << {off, 3'b000};
   assign rdata     = (mem[widx] >> {off, 3'b000}) & len_mask;

   // Response payload formed from the request being accepted.
   always_comb begin
      test      = 2'b00;
      resp_data = '0;
      if (!is_read && !is_wr) test = 2'b10;
      else if (oob)           test = 2'b01;
      else if (is_read)       resp_data = rdata;
   end

   assign do_write = (state == IDLE) && dmem.reqstream_val && is_wr && !oob;

   // Storage write; contents deliberately survive reset.
   always_ff @(posedge clk) begin
      if (do_write)
         mem[widx] <= (mem[widx] & ~lane_mask) | (shifted_w & lane_mask);
   end

   // Control FSM with registered response outputs.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state    <= IDLE;
         cnt      <= '0;
         resp_val <= 1'b0;
         resp_msg <= '0;
      end else begin
         unique case (state)
            IDLE: if (dmem.reqstream_val) begin
               resp_msg <= {typ, opq, test, len, resp_data};
               if (p_latency == 1) begin
                  state    <= RESP;
                  resp_val <= 1'b1;
               end else begin
                  cnt   <= 4'(p_latency - 1);
                  state <= WAIT;
               end
            end
            WAIT: if (cnt == 4'd1) begin
               cnt      <= '0;
               state    <= RESP;
               resp_val <= 1'b1;
            end else begin
               cnt <= cnt - 4'd1;
            end
            RESP: if (dmem.respstream_rdy) begin
               state    <= IDLE;
               resp_val <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign dmem.reqstream_rdy  = (state == IDLE);
   assign dmem.respstream_val = resp_val;
   assign dmem.respstream_msg = resp_msg;
endmodule

// File: tb/tb_proc_dmem_responder.sv
// Scoreboard bench for proc_dmem_responder at latency 1 and latency 4.
// Honours PROC_DMEM_RESPONDER_BOUNDS_CHECK_EN for the bounds/wrap case.
module tb_proc_dmem_responder;
   logic clk = 1'b0;
   logic reset = 1'b0;
   int   n_chk = 0;
   int   n_fail = 0;
   logic [46:0] exp1[$];
   logic [46:0] exp4[$];

   proc_dmem_responder_if if1 ();
   proc_dmem_responder_if if4 ();

   proc_dmem_responder #(.p_mem_words(256), .p_latency(1)) u_dut1 (
      .clk(clk), .reset(reset), .dmem(if1)
   );
   proc_dmem_responder #(.p_mem_words(256), .p_latency(4)) u_dut4 (
      .clk(clk), .reset(reset), .dmem(if4)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [46:0] act,
                      input logic [46:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", nm, act, exp);
      end
   endtask

   function automatic logic [76:0] rq(input logic [2:0] t, input logic [7:0] o,
                                      input logic [31:0] a, input logic [1:0] l,
                                      input logic [31:0] dt);
      return {t, o, a, l, dt};
   endfunction

   function automatic logic [46:0] rs(input logic [2:0] t, input logic [7:0] o,
                                      input logic [1:0] ts, input logic [1:0] l,
                                      input logic [31:0] dt);
      return {t, o, ts, l, dt};
   endfunction

   function automatic logic req_rdy(input int d);
      return (d == 1) ? if1.reqstream_rdy : if4.reqstream_rdy;
   endfunction

   function automatic logic rsp_val(input int d);
      return (d == 1) ? if1.respstream_val : if4.respstream_val;
   endfunction

   function automatic logic [46:0] rsp_msg(input int d);
      return (d == 1) ? if1.respstream_msg : if4.respstream_msg;
   endfunction

   task automatic set_req(input int d, input logic v, input logic [76:0] m);
      if (d == 1) begin
         if1.reqstream_val = v;
         if1.reqstream_msg = m;
      end else begin
         if4.reqstream_val = v;
         if4.reqstream_msg = m;
      end
   endtask

   task automatic set_rr(input int d, input logic v);
      if (d == 1) if1.respstream_rdy = v;
      else        if4.respstream_rdy = v;
   endtask

   // d is both the DUT selector and its latency (1 or 4).
   task automatic send(input int d, input logic [76:0] m,
                       input logic [46:0] e, input int hold);
      int cyc;
      logic [46:0] snap;
      @(posedge clk); #1;
      chk("req_rdy_idle", 47'(req_rdy(d)), 47'd1);
      set_rr(d, hold == 0);
      set_req(d, 1'b1, m);
      @(posedge clk);
      if (d == 1) exp1.push_back(e);
      else        exp4.push_back(e);
      #1 set_req(d, 1'b0, '0);
      cyc = 0;
      while (!rsp_val(d) && cyc < 20) begin
         @(posedge clk); #1;
         cyc++;
      end
      chk("latency", 47'(cyc + 1), 47'(d));
      if (hold > 0) begin
         snap = rsp_msg(d);
         for (int i = 0; i < hold; i++) begin
            chk("bp_val", 47'(rsp_val(d)), 47'd1);
            chk("bp_msg", rsp_msg(d), snap);
            chk("bp_req_rdy", 47'(req_rdy(d)), 47'd0);
            @(posedge clk); #1;
         end
         set_rr(d, 1'b1);
      end
      @(posedge clk); #1;
      chk("post_hs_req_rdy", 47'(req_rdy(d)), 47'd1);
      chk("post_hs_val", 47'(rsp_val(d)), 47'd0);
   endtask

   // Monitor: compare at every response handshake against the scoreboard.
   always @(negedge clk) begin
      if (if1.respstream_val && if1.respstream_rdy) begin
         if (exp1.size() == 0) chk("resp1_unexpected", if1.respstream_msg, '0);
         else chk("resp1", if1.respstream_msg, exp1.pop_front());
      end
      if (if4.respstream_val && if4.respstream_rdy) begin
         if (exp4.size() == 0) chk("resp4_unexpected", if4.respstream_msg, '0);
         else chk("resp4", if4.respstream_msg, exp4.pop_front());
      end
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      set_req(1, 1'b0, '0);
      set_req(4, 1'b0, '0);
      set_rr(1, 1'b1);
      set_rr(4, 1'b1);
      #12;
      chk("rst_req_rdy1", 47'(if1.reqstream_rdy), 47'd1);
      chk("rst_val1", 47'(if1.respstream_val), 47'd0);
      chk("rst_msg1", if1.respstream_msg, 47'd0);
      chk("rst_msg4", if4.respstream_msg, 47'd0);
      @(posedge clk); #1 reset = 1'b1;

      send(1, rq(2, 8'h05, 32'h10, 0, 32'hDEADBEEF), rs(2, 8'h05, 0, 0, 0), 0);
      send(1, rq(0, 8'h06, 32'h10, 0, 0), rs(0, 8'h06, 0, 0, 32'hDEADBEEF), 0);

      send(1, rq(1, 8'h10, 32'h20, 0, 32'hAABBCCDD), rs(1, 8'h10, 0, 0, 0), 0);
      send(1, rq(1, 8'h11, 32'h21, 1, 32'h00000011), rs(1, 8'h11, 0, 1, 0), 0);
      send(1, rq(0, 8'h12, 32'h20, 0, 0), rs(0, 8'h12, 0, 0, 32'hAABB11DD), 0);
      send(1, rq(0, 8'h13, 32'h22, 2, 0), rs(0, 8'h13, 0, 2, 32'h0000AABB), 0);
      send(1, rq(0, 8'h14, 32'h23, 3, 0), rs(0, 8'h14, 0, 3, 32'h000000AA), 0);
      send(1, rq(0, 8'h15, 32'h21, 1, 0), rs(0, 8'h15, 0, 1, 32'h00000011), 0);

      send(1, rq(3, 8'h20, 32'h20, 0, 32'hFFFFFFFF), rs(3, 8'h20, 2'b10, 0, 0), 0);
      send(1, rq(0, 8'h21, 32'h20, 0, 0), rs(0, 8'h21, 0, 0, 32'hAABB11DD), 0);

      send(1, rq(1, 8'h30, 32'h0, 0, 32'hCAFEF00D), rs(1, 8'h30, 0, 0, 0), 0);
`ifdef PROC_DMEM_RESPONDER_BOUNDS_CHECK_EN
      send(1, rq(1, 8'h31, 32'h400, 0, 32'h12345678), rs(1, 8'h31, 2'b01, 0, 0), 0);
      send(1, rq(0, 8'h32, 32'h0, 0, 0), rs(0, 8'h32, 0, 0, 32'hCAFEF00D), 0);
      send(1, rq(0, 8'h33, 32'h400, 0, 0), rs(0, 8'h33, 2'b01, 0, 0), 0);
`else
      send(1, rq(1, 8'h31, 32'h400, 0, 32'h12345678), rs(1, 8'h31, 0, 0, 0), 0);
      send(1, rq(0, 8'h32, 32'h0, 0, 0), rs(0, 8'h32, 0, 0, 32'h12345678), 0);
`endif

      send(4, rq(1, 8'h40, 32'h8, 0, 32'h0BADCAFE), rs(1, 8'h40, 0, 0, 0), 0);
      send(4, rq(0, 8'h41, 32'h8, 0, 0), rs(0, 8'h41, 0, 0, 32'h0BADCAFE), 5);
      send(4, rq(0, 8'h44, 32'h9, 2, 0), rs(0, 8'h44, 0, 2, 32'h0000ADCA), 0);

      @(posedge clk); #1;
      set_req(4, 1'b1, rq(0, 8'h42, 32'h4, 0, 0));
      @(posedge clk); #1 set_req(4, 1'b0, '0);
      @(posedge clk); #1;
      reset = 1'b0;
      #1;
      chk("midrst_req_rdy", 47'(if4.reqstream_rdy), 47'd1);
      chk("midrst_val", 47'(if4.respstream_val), 47'd0);
      chk("midrst_msg", if4.respstream_msg, 47'd0);
      @(posedge clk); #1 reset = 1'b1;
      repeat (6) @(posedge clk);
      #1 chk("no_stale_resp", 47'(if4.respstream_val), 47'd0);
      send(4, rq(0, 8'h43, 32'h8, 0, 0), rs(0, 8'h43, 0, 0, 32'h0BADCAFE), 0);
      send(1, rq(0, 8'h50, 32'h20, 0, 0), rs(0, 8'h50, 0, 0, 32'hAABB11DD), 0);

      repeat (3) @(posedge clk);
      #1 chk("queues_drained", 47'(exp1.size() + exp4.size()), 47'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/proc_dmem_responder.md
# proc_dmem_responder

Single-outstanding memory responder that serves the processor's data-memory request stream and returns matching responses over a val/rdy stream. It sits on the far side of the processor's `dmem` port, in test harnesses and single-core builds, in place of the full memory system. It holds a word-addressed storage array and supports read, write and init requests with byte-length sub-word access. Response latency is fixed and programmable.

## Interface

**Parameters**
- `p_mem_words`, default 256: storage depth in 32-bit words; must be a power of two, at least 4.
- `p_latency`, default 1: cycles from request accept to first `respstream_val`; range 1–15.

**Ports**
- `clk` in 1: clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `reqstream_val` in 1: request valid.
- `reqstream_rdy` out 1: request ready.
- `reqstream_msg` in 77: `mem_req_4B_t` = {type[2:0], opaque[7:0], addr[31:0], len[1:0], data[31:0]}.
- `respstream_val` out 1: response valid.
- `respstream_rdy` in 1: response ready.
- `respstream_msg` out 47: `mem_resp_4B_t` = {type[2:0], opaque[7:0], test[1:0], len[1:0], data[31:0]}.

## Operation

**State machine (IDLE, WAIT, RESP)**
- IDLE
  - `reqstream_rdy` = 1.
  - On `reqstream_val`, the request is accepted.
  - If `p_latency` = 1, go to RESP; otherwise load the counter with `p_latency` − 1 and go to WAIT.
- WAIT
  - Decrement the counter each cycle.
  - When the counter reaches 1, go to RESP.
- RESP
  - `respstream_val` = 1 and the response register is held stable.
  - When `respstream_rdy` = 1, go to IDLE.
- `reqstream_rdy` = 0 in WAIT and RESP. At most one request is outstanding.

**Address and length rules**
- Word index = `addr[log2(p_mem_words)+1:2]`; byte offset `off` = `addr[1:0]`.
- Effective byte count `n` = 4 when `len` = 0, otherwise `n` = `len`.
- Byte lanes `off` … `off`+`n`−1 are active. Lanes above 3 are dropped; there is no crossing into the next word.

**Request types**
- **READ (0)**
  - Response data = stored word shifted right by 8·`off`, then masked to `n` bytes.
  - Upper bytes are zero.
- **WRITE (1) and INIT (2)**
  - Write `data` bytes 0…`n`−1 into the active lanes at the accept edge.
  - Response data = 0.
- **Any other type**: no array access; response data = 0 and test = 2'b10.

**Response fields**
- Response type, opaque and len echo the accepted request.
- test = 2'b00 for a normal response.
- Read data is sampled at the accept edge, so a read reflects every write accepted earlier.

**Reset (`reset` low)**
- State goes to IDLE, the counter to 0, and `respstream_val` to 0.
- The response register clears to 0.
- An in-flight request is discarded without a response.
- Array contents are not reset. A write committed before reset remains.

## Timing

**Reset values**
- `reqstream_rdy` = 1.
- `respstream_val` = 0.
- `respstream_msg` = 0.

**Latency**
- Request accepted at edge E0.
- `respstream_val` rises exactly `p_latency` cycles after E0.

**Throughput**
- Back-to-back requests with `respstream_rdy` held at 1 are accepted every `p_latency` + 1 cycles.
- The response handshake cycle is followed by IDLE. `reqstream_rdy` is never 1 in the same cycle as a `respstream_val` handshake.

**Backpressure**
- While `respstream_rdy` = 0 in RESP, the response is held indefinitely and unchanged.

**Combinational paths**
- `respstream_*` outputs come from registers only.
- `reqstream_rdy` depends only on state.
- There is no combinational path from input to output.

## Configuration

`PROC_DMEM_RESPONDER_BOUNDS_CHECK_EN`

**Defined**
- Any request with `addr[31:log2(p_mem_words)+2]` ≠ 0 is out of bounds.
- An out-of-bounds request performs no array write.
- Its response has data = 0 and test = 2'b01; latency is unchanged.

**Undefined**
- Upper address bits are ignored, so addresses wrap modulo 4·`p_mem_words` bytes.
- test is never 2'b01.

## Test plan

- **Basic write/read**, `p_latency` = 1:
  - Send INIT addr 0x10 data 0xDEADBEEF, opaque 0x05, then READ addr 0x10 len 0, opaque 0x06.
  - Expect responses {type 2, opaque 0x05, data 0} and then {type 0, opaque 0x06, data 0xDEADBEEF}.
  - Each `respstream_val` is 1 cycle after its accept.
- **Sub-word access**:
  - Write 0xAABBCCDD to 0x20, then WRITE addr 0x21 len 1 data 0x11.
  - READ addr 0x20 len 0 → 0xAABB11DD.
  - READ addr 0x22 len 2 → 0x0000AABB.
- **Latency and backpressure**, `p_latency` = 4:
  - `respstream_val` rises 4 cycles after accept.
  - Hold `respstream_rdy` = 0 for 5 cycles: message stable and `reqstream_rdy` = 0 throughout.
  - Next request is accepted the cycle after the handshake.
- **Reset mid-operation**:
  - Assert `reset` low during WAIT of a READ.
  - Outputs go to their reset values immediately; no response is ever produced for that request.
  - A following READ of a previously written word returns the stored data.
- **Bounds and wrap**:
  - `p_mem_words` = 256, WRITE addr 0x400 data 0x12345678.
  - With the macro: test = 2'b01, and a READ of 0x0 is unchanged.
  - Without the macro: a READ of 0x0 returns 0x12345678.
- **Unsupported type**: type 3 → response test = 2'b10, data 0, and no array change.
